// File: rtl/saes_key_sched_ctrl.sv
// S-AES key schedule: derives K0..K2 from a 16-bit key, one round key per clock.
// Define KEYSCHED_ZEROIZE_EN to add a synchronous zeroize input.
module saes_key_sched_ctrl #(
  parameter logic [7:0] RCON1 = 8'h80,
  parameter logic [7:0] RCON2 = 8'h30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] key_in,
`ifdef KEYSCHED_ZEROIZE_EN
  input  logic        zeroize,
`endif
  output logic        busy,
  output logic        done,
  output logic        keys_valid,
  input  logic [1:0]  rk_sel,
  output logic [15:0] rk_out
);

  typedef enum logic [1:0] {
    IDLE,
    EXP1,
    EXP2,
    READY
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  w_hi_q;
  logic [7:0]  w_lo_q;
  logic [15:0] rk_q [3];
  logic        done_q;
  logic        zero_req;
  logic        accept;
  logic        load_rk1;
  logic        load_rk2;
  logic [7:0]  g_rc;
  logic [7:0]  g_out;
  logic [7:0]  nxt_hi;
  logic [7:0]  nxt_lo;

`ifdef KEYSCHED_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  function automatic logic [3:0] sbox(input logic [3:0] n);
    logic [3:0] s;
    unique case (n)
      4'h0: s = 4'h9;
      4'h1: s = 4'h4;
      4'h2: s = 4'hA;
      4'h3: s = 4'hB;
      4'h4: s = 4'hD;
      4'h5: s = 4'h1;
      4'h6: s = 4'h8;
      4'h7: s = 4'h5;
      4'h8: s = 4'h6;
      4'h9: s = 4'h2;
      4'hA: s = 4'h0;
      4'hB: s = 4'h3;
      4'hC: s = 4'hC;
      4'hD: s = 4'hE;
      4'hE: s = 4'hF;
      default: s = 4'h7;
    endcase
    return s;
  endfunction

  // Shared g-unit: w_lo holds w1 in EXP1 and w3 in EXP2.
  assign g_rc   = (state_q == EXP2) ? RCON2 : RCON1;
  assign g_out  = {sbox(w_lo_q[3:0]), sbox(w_lo_q[7:4])} ^ g_rc;
  assign nxt_hi = w_hi_q ^ g_out;
  assign nxt_lo = nxt_hi ^ w_lo_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control decode.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    load_rk1   = 1'b0;
    load_rk2   = 1'b0;
    busy       = 1'b0;
    keys_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = EXP1;
        end
      end
      EXP1: begin
        busy     = 1'b1;
        load_rk1 = 1'b1;
        state_d  = EXP2;
      end
      EXP2: begin
        busy     = 1'b1;
        load_rk2 = 1'b1;
        state_d  = READY;
      end
      READY: begin
        keys_valid = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = EXP1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (zero_req) begin
      accept   = 1'b0;
      load_rk1 = 1'b0;
      load_rk2 = 1'b0;
      state_d  = IDLE;
    end
  end

  // Round-key file, word registers and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_hi_q <= '0;
      w_lo_q <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < 3; i++) rk_q[i] <= '0;
    end else if (zero_req) begin
      w_hi_q <= '0;
      w_lo_q <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < 3; i++) rk_q[i] <= '0;
    end else begin
      done_q <= load_rk2;
      if (accept) begin
        rk_q[0] <= key_in;
        w_hi_q  <= key_in[15:8];
        w_lo_q  <= key_in[7:0];
      end
      if (load_rk1) begin
        rk_q[1] <= {nxt_hi, nxt_lo};
        w_hi_q  <= nxt_hi;
        w_lo_q  <= nxt_lo;
      end
      if (load_rk2) begin
        rk_q[2] <= {nxt_hi, nxt_lo};
      end
    end
  end

  assign done = done_q;

  // Combinational round-key read port.
  always_comb begin
    rk_out = '0;
    unique case (rk_sel)
      2'd0:    rk_out = rk_q[0];
      2'd1:    rk_out = rk_q[1];
      2'd2:    rk_out = rk_q[2];
      default: rk_out = '0;
    endcase
  end

endmodule
